// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and the data memory.
interface mem_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_ack;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM register, req/ack data-memory port with timeout,
// and the MEM/WB register feeding write-back.
module mem_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] aluout_exe,
    input  logic [WIDTH-1:0] writedata_exe,
    input  logic [4:0]       regaddr_exe,
    input  logic             regwrite_exe,
    input  logic             memtoreg_exe,
    input  logic             memread_exe,
    input  logic             memwrite_exe,
    output logic             stall_mem,
    output logic [WIDTH-1:0] aluout_mem,
    output logic [4:0]       regaddr_mem,
    output logic             regwrite_mem,
    mem_stage_if.master      dmem,
    output logic [WIDTH-1:0] readdata_wb,
    output logic [WIDTH-1:0] aluout_wb,
    output logic [4:0]       regaddr_wb,
    output logic             regwrite_wb,
    output logic             memtoreg_wb,
    output logic             mem_err
);
    typedef enum logic [1:0] {StIdle, StWait, StAbort} state_e;

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic             mem_err_q;

    logic [WIDTH-1:0] aluout_q, wdata_q;
    logic [4:0]       regaddr_q;
    logic             regwrite_q, memtoreg_q, memread_q, memwrite_q;

    logic [WIDTH-1:0] readdata_wb_q, aluout_wb_q;
    logic [4:0]       regaddr_wb_q;
    logic             regwrite_wb_q, memtoreg_wb_q;

    logic             memop, is_abort, is_load;

    always_comb begin
        memop            = memread_q | memwrite_q;
        is_abort         = (state_q == StAbort);
        // Both read and write set is treated as a store.
        is_load          = memread_q & ~memwrite_q;
        dmem.dmem_req    = memop & ~is_abort;
        dmem.dmem_we     = memwrite_q;
        dmem.dmem_addr   = aluout_q;
        dmem.dmem_wdata  = wdata_q;
        stall_mem        = memop & ~dmem.dmem_ack & ~is_abort;
        aluout_mem       = aluout_q;
        regaddr_mem      = regaddr_q;
        regwrite_mem     = regwrite_q;
        readdata_wb      = readdata_wb_q;
        aluout_wb        = aluout_wb_q;
        regaddr_wb       = regaddr_wb_q;
        regwrite_wb      = regwrite_wb_q;
        memtoreg_wb      = memtoreg_wb_q;
        mem_err          = mem_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (memop && !dmem.dmem_ack) begin
                        state_q <= StWait;
                        cnt_q   <= 8'd1;
                    end
                end
                StWait: begin
                    if (dmem.dmem_ack) begin
                        state_q <= StIdle;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q == 8'(TIMEOUT)) begin
                        state_q   <= StAbort;
                        cnt_q     <= 8'd0;
                        mem_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StAbort: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aluout_q   <= '0;
            wdata_q    <= '0;
            regaddr_q  <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (!stall_mem) begin
            aluout_q   <= aluout_exe;
            wdata_q    <= writedata_exe;
            regaddr_q  <= regaddr_exe;
            regwrite_q <= regwrite_exe;
            memtoreg_q <= memtoreg_exe;
            memread_q  <= memread_exe;
            memwrite_q <= memwrite_exe;
        end
    end

    // MEM/WB is never stalled; stalls and aborts push a bubble by clearing the controls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            readdata_wb_q <= '0;
            aluout_wb_q   <= '0;
            regaddr_wb_q  <= '0;
            regwrite_wb_q <= 1'b0;
            memtoreg_wb_q <= 1'b0;
        end else if (stall_mem || is_abort) begin
            regwrite_wb_q <= 1'b0;
            memtoreg_wb_q <= 1'b0;
        end else begin
            aluout_wb_q   <= aluout_q;
            regaddr_wb_q  <= regaddr_q;
            regwrite_wb_q <= regwrite_q;
            memtoreg_wb_q <= memtoreg_q;
            if (is_load && dmem.dmem_ack) begin
                readdata_wb_q <= dmem.dmem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected MEM/WB results checked with assertions.
module tb_mem_stage;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 15;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] aluout_exe, writedata_exe;
    logic [4:0]  regaddr_exe;
    logic        regwrite_exe, memtoreg_exe, memread_exe, memwrite_exe;
    logic        stall_mem, regwrite_mem, regwrite_wb, memtoreg_wb, mem_err;
    logic [31:0] aluout_mem, readdata_wb, aluout_wb;
    logic [4:0]  regaddr_mem, regaddr_wb;

    int errors = 0;
    int checks = 0;
    wb_t sb[$];
    logic [31:0] exp_rdata;
    int cnt;

    mem_stage_if #(.WIDTH(WIDTH)) mif ();

    mem_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .aluout_exe    (aluout_exe),
        .writedata_exe (writedata_exe),
        .regaddr_exe   (regaddr_exe),
        .regwrite_exe  (regwrite_exe),
        .memtoreg_exe  (memtoreg_exe),
        .memread_exe   (memread_exe),
        .memwrite_exe  (memwrite_exe),
        .stall_mem     (stall_mem),
        .aluout_mem    (aluout_mem),
        .regaddr_mem   (regaddr_mem),
        .regwrite_mem  (regwrite_mem),
        .dmem          (mif.master),
        .readdata_wb   (readdata_wb),
        .aluout_wb     (aluout_wb),
        .regaddr_wb    (regaddr_wb),
        .regwrite_wb   (regwrite_wb),
        .memtoreg_wb   (memtoreg_wb),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_exe(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input logic rw, input logic m2r, input logic mr, input logic mw);
        aluout_exe    = alu;
        writedata_exe = wd;
        regaddr_exe   = rd;
        regwrite_exe  = rw;
        memtoreg_exe  = m2r;
        memread_exe   = mr;
        memwrite_exe  = mw;
    endtask

    task automatic push(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                        input logic m2r, input logic [31:0] rdata);
        wb_t e;
        e.alu = alu; e.rd = rd; e.rw = rw; e.m2r = m2r; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".aluout_wb"}, aluout_wb, e.alu);
            chk({tag, ".regaddr_wb"}, 32'(regaddr_wb), 32'(e.rd));
            chk({tag, ".regwrite_wb"}, 32'(regwrite_wb), 32'(e.rw));
            chk({tag, ".memtoreg_wb"}, 32'(memtoreg_wb), 32'(e.m2r));
            chk({tag, ".readdata_wb"}, readdata_wb, e.rdata);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'h0;
        exp_rdata = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        chk("rst.stall", 32'(stall_mem), 32'd0);
        chk("rst.req", 32'(mif.dmem_req), 32'd0);
        chk("rst.mem_err", 32'(mem_err), 32'd0);
        chk("rst.aluout_mem", aluout_mem, 32'h0);
        chk("rst.regwrite_wb", 32'(regwrite_wb), 32'd0);
        chk("rst.aluout_wb", aluout_wb, 32'h0);

        // ALU op: two edges to MEM/WB, never stalls
        set_exe(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'h10, 5'd5, 1'b1, 1'b0, exp_rdata);
        tick();
        settle();
        chk("alu.stall", 32'(stall_mem), 32'd0);
        chk("alu.req", 32'(mif.dmem_req), 32'd0);
        chk("alu.aluout_mem", aluout_mem, 32'h10);
        chk("alu.regaddr_mem", 32'(regaddr_mem), 32'd5);
        chk("alu.regwrite_mem", 32'(regwrite_mem), 32'd1);
        set_exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_wb("alu");

        // Zero-wait load
        set_exe(32'h40, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'hDEADBEEF;
        settle();
        chk("ld0.req", 32'(mif.dmem_req), 32'd1);
        chk("ld0.we", 32'(mif.dmem_we), 32'd0);
        chk("ld0.addr", mif.dmem_addr, 32'h40);
        chk("ld0.stall", 32'(stall_mem), 32'd0);
        exp_rdata = 32'hDEADBEEF;
        push(32'h40, 5'd7, 1'b1, 1'b1, exp_rdata);
        set_exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'h0;
        check_wb("ld0");

        // Store with three wait cycles, ack on the 4th req cycle
        set_exe(32'h80, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            mif.dmem_ack = (i == 3);
            settle();
            chk("st3.req", 32'(mif.dmem_req), 32'd1);
            chk("st3.we", 32'(mif.dmem_we), 32'd1);
            chk("st3.addr", mif.dmem_addr, 32'h80);
            chk("st3.wdata", mif.dmem_wdata, 32'h1234);
            if (stall_mem) cnt++;
            tick();
            if (i < 3) chk("st3.bubble_rw", 32'(regwrite_wb), 32'd0);
        end
        mif.dmem_ack = 1'b0;
        chk("st3.stall_cycles", 32'(cnt), 32'd3);
        push(32'h80, 5'd0, 1'b0, 1'b0, exp_rdata);
        check_wb("st3");

        // Timeout: ack never arrives
        set_exe(32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_exe(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (!mif.dmem_req) break;
            cnt++;
            chk("to.stall", 32'(stall_mem), 32'd1);
            tick();
        end
        chk("to.req_cycles", 32'(cnt), 32'(TIMEOUT + 1));
        chk("to.abort_stall", 32'(stall_mem), 32'd0);
        chk("to.abort_req", 32'(mif.dmem_req), 32'd0);
        chk("to.mem_err", 32'(mem_err), 32'd1);
        tick();
        set_exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to.bubble_rw", 32'(regwrite_wb), 32'd0);
        chk("to.bubble_m2r", 32'(memtoreg_wb), 32'd0);
        chk("to.next_aluout_mem", aluout_mem, 32'h55);
        push(32'h55, 5'd3, 1'b1, 1'b0, exp_rdata);
        tick();
        check_wb("to.next");
        chk("to.mem_err_sticky", 32'(mem_err), 32'd1);

        // Reset while waiting with counter at 2
        set_exe(32'h200, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk("rstw.stall_before", 32'(stall_mem), 32'd1);
        rst_n = 1'b0;
        set_exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("rstw.req", 32'(mif.dmem_req), 32'd0);
        chk("rstw.stall", 32'(stall_mem), 32'd0);
        chk("rstw.aluout_wb", aluout_wb, 32'h0);
        chk("rstw.readdata_wb", readdata_wb, 32'h0);
        chk("rstw.regaddr_wb", 32'(regaddr_wb), 32'd0);
        chk("rstw.regwrite_wb", 32'(regwrite_wb), 32'd0);
        chk("rstw.mem_err", 32'(mem_err), 32'd0);
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'hFFFF0000;
        settle();
        chk("rstw.late_ack_stall", 32'(stall_mem), 32'd0);
        tick();
        mif.dmem_ack = 1'b0;
        chk("rstw.late_ack_readdata", readdata_wb, 32'h0);
        chk("rstw.late_ack_rw", 32'(regwrite_wb), 32'd0);
        exp_rdata = 32'h0;

        // Back-to-back: load with one wait cycle, then zero-wait store
        set_exe(32'h300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_exe(32'h304, 32'hCAFE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        settle();
        chk("b2b.ld_req", 32'(mif.dmem_req), 32'd1);
        chk("b2b.ld_addr", mif.dmem_addr, 32'h300);
        if (stall_mem) cnt++;
        tick();
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'h0BADF00D;
        settle();
        chk("b2b.ld_ack_stall", 32'(stall_mem), 32'd0);
        exp_rdata = 32'h0BADF00D;
        push(32'h300, 5'd6, 1'b1, 1'b1, exp_rdata);
        tick();
        mif.dmem_ack = 1'b0;
        check_wb("b2b.ld");
        chk("b2b.st_req", 32'(mif.dmem_req), 32'd1);
        chk("b2b.st_we", 32'(mif.dmem_we), 32'd1);
        chk("b2b.st_addr", mif.dmem_addr, 32'h304);
        chk("b2b.st_wdata", mif.dmem_wdata, 32'hCAFE);
        mif.dmem_ack = 1'b1;
        settle();
        if (stall_mem) cnt++;
        set_exe(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h304, 5'd0, 1'b0, 1'b0, exp_rdata);
        tick();
        mif.dmem_ack = 1'b0;
        check_wb("b2b.st");
        chk("b2b.stall_cycles", 32'(cnt), 32'd1);
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
